// File: rtl/mbi5153_pkg.sv
// Shared MBI5153 command definitions used by the serial transmitter and the
// command decoder: command codes, latch lengths and decoder state encoding.
package mbi5153_pkg;

    localparam logic [3:0] CMD_DL        = 4'h1;
    localparam logic [3:0] CMD_VSYNC     = 4'h2;
    localparam logic [3:0] CMD_WRC1      = 4'h3;
    localparam logic [3:0] CMD_RDC1      = 4'h4;
    localparam logic [3:0] CMD_START_CED = 4'h5;
    localparam logic [3:0] CMD_WRC2      = 4'h6;
    localparam logic [3:0] CMD_STOP_CED  = 4'h7;
    localparam logic [3:0] CMD_SRST      = 4'h8;
    localparam logic [3:0] CMD_RDC2      = 4'h9;
    localparam logic [3:0] CMD_WRC3      = 4'hA;
    localparam logic [3:0] CMD_PREA      = 4'hB;
    localparam logic [3:0] CMD_UNKNOWN   = 4'hF;

    localparam logic [4:0] CMD_DL_DCLK        = 5'd1;
    localparam logic [4:0] CMD_VSYNC_DCLK     = 5'd3;
    localparam logic [4:0] CMD_WRC1_DCLK      = 5'd4;
    localparam logic [4:0] CMD_RDC1_DCLK      = 5'd5;
    localparam logic [4:0] CMD_START_CED_DCLK = 5'd7;
    localparam logic [4:0] CMD_WRC2_DCLK      = 5'd8;
    localparam logic [4:0] CMD_STOP_CED_DCLK  = 5'd9;
    localparam logic [4:0] CMD_SRST_DCLK      = 5'd10;
    localparam logic [4:0] CMD_RDC2_DCLK      = 5'd11;
    localparam logic [4:0] CMD_WRC3_DCLK      = 5'd12;
    localparam logic [4:0] CMD_PREA_DCLK      = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH_HI,
        ST_DECODE
    } dec_state_e;

    function automatic logic [3:0] cmd_decode(input logic [4:0] len);
        logic [3:0] c;
        c = CMD_UNKNOWN;
        case (len)
            CMD_DL_DCLK:        c = CMD_DL;
            CMD_VSYNC_DCLK:     c = CMD_VSYNC;
            CMD_WRC1_DCLK:      c = CMD_WRC1;
            CMD_RDC1_DCLK:      c = CMD_RDC1;
            CMD_START_CED_DCLK: c = CMD_START_CED;
            CMD_WRC2_DCLK:      c = CMD_WRC2;
            CMD_STOP_CED_DCLK:  c = CMD_STOP_CED;
            CMD_SRST_DCLK:      c = CMD_SRST;
            CMD_RDC2_DCLK:      c = CMD_RDC2;
            CMD_WRC3_DCLK:      c = CMD_WRC3;
            CMD_PREA_DCLK:      c = CMD_PREA;
            default:            c = CMD_UNKNOWN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mbi5153_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input bit with rise/fall
// detection on the synchronized level.
module mbi5153_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/mbi5153_cmd_decoder.sv
// MBI5153 serial command decoder: counts DCLK rises under LATCH and decodes.
// Optional WRC bit-length check enabled by MBI5153_DEC_LEN_CHECK_EN.
module mbi5153_cmd_decoder
    import mbi5153_pkg::*;
#(
    parameter int NUM_IC_CHAIN = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        DCLK,
    input  logic        LATCH,
    input  logic        R,
    input  logic        G,
    input  logic        B,
    output logic        CMD_VALID,
    output logic [3:0]  CMD,
    output logic [4:0]  LATCH_LEN,
    output logic [15:0] DATA_R,
    output logic [15:0] DATA_G,
    output logic [15:0] DATA_B,
    output logic        CMD_ERR,
    output logic        ACTIVE,
    output logic        LEN_ERR
);

    logic dclk_rise, lat_s, lat_rise, lat_fall, r_s, g_s, b_s;
    logic [6:0] unused_edges;

    mbi5153_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dclk (
        .clk_i(CLK), .rst_ni(RESET_N), .d_i(DCLK),
        .q_o(unused_edges[0]), .rise_o(dclk_rise), .fall_o(unused_edges[1]));
    mbi5153_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
        .clk_i(CLK), .rst_ni(RESET_N), .d_i(LATCH),
        .q_o(lat_s), .rise_o(lat_rise), .fall_o(lat_fall));
    mbi5153_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_r (
        .clk_i(CLK), .rst_ni(RESET_N), .d_i(R),
        .q_o(r_s), .rise_o(unused_edges[2]), .fall_o(unused_edges[3]));
    mbi5153_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_g (
        .clk_i(CLK), .rst_ni(RESET_N), .d_i(G),
        .q_o(g_s), .rise_o(unused_edges[4]), .fall_o(unused_edges[5]));
    mbi5153_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_b (
        .clk_i(CLK), .rst_ni(RESET_N), .d_i(B),
        .q_o(b_s), .rise_o(unused_edges[6]), .fall_o());

    dec_state_e state_q, state_d;
    logic [9:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] shr_q, shr_d, shg_q, shg_d, shb_q, shb_d;
    logic [SYNC_STAGES:0] settle_q;
    logic        armed_q, armed_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [4:0]  len_q, len_d;
    logic [15:0] dr_q, dr_d, dg_q, dg_d, db_q, db_d;
    logic        lat_hi;

    // A DCLK rise coincident with the LATCH fall still belongs to the command.
    assign lat_hi  = lat_s | lat_fall;
    // Arm only once the synchronizers hold real pin values and LATCH is low.
    assign armed_d = armed_q | (settle_q[SYNC_STAGES] & ~lat_s);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        lat_cnt_d = lat_cnt_q;
        shr_d     = shr_q;
        shg_d     = shg_q;
        shb_d     = shb_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cmd_d     = cmd_q;
        len_d     = len_q;
        dr_d      = dr_q;
        dg_d      = dg_q;
        db_d      = db_q;
        if (dclk_rise) begin
            shr_d = {shr_q[14:0], r_s};
            shg_d = {shg_q[14:0], g_s};
            shb_d = {shb_q[14:0], b_s};
            if (bit_cnt_q != 10'h3FF) bit_cnt_d = bit_cnt_q + 10'd1;
            if (lat_hi && lat_cnt_q != 5'h1F) lat_cnt_d = lat_cnt_q + 5'd1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (lat_fall) begin
                    bit_cnt_d = '0;
                    lat_cnt_d = '0;
                end else if (lat_rise && armed_q) begin
                    state_d = ST_LATCH_HI;
                end
            end
            ST_LATCH_HI: begin
                if (lat_fall) begin
                    if (lat_cnt_d != 5'd0) begin
                        state_d = ST_DECODE;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DECODE: begin
                state_d   = ST_IDLE;
                valid_d   = 1'b1;
                cmd_d     = cmd_decode(lat_cnt_q);
                err_d     = (cmd_d == CMD_UNKNOWN);
                len_d     = lat_cnt_q;
                dr_d      = shr_q;
                dg_d      = shg_q;
                db_d      = shb_q;
                bit_cnt_d = {9'd0, dclk_rise};
                lat_cnt_d = {4'd0, dclk_rise & lat_hi};
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            shr_q     <= '0;
            shg_q     <= '0;
            shb_q     <= '0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
            len_q     <= '0;
            dr_q      <= '0;
            dg_q      <= '0;
            db_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            shr_q     <= shr_d;
            shg_q     <= shg_d;
            shb_q     <= shb_d;
            settle_q  <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            dr_q      <= dr_d;
            dg_q      <= dg_d;
            db_q      <= db_d;
        end
    end

`ifdef MBI5153_DEC_LEN_CHECK_EN
    localparam logic [9:0] WRC_BITS = 10'(16 * NUM_IC_CHAIN);
    logic len_err_q, len_err_d;

    always_comb begin
        len_err_d = 1'b0;
        if (state_q == ST_DECODE) begin
            len_err_d = (cmd_d == CMD_WRC1 || cmd_d == CMD_WRC2 ||
                         cmd_d == CMD_WRC3) && (bit_cnt_q != WRC_BITS);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) len_err_q <= 1'b0;
        else          len_err_q <= len_err_d;
    end

    assign LEN_ERR = len_err_q;
`else
    assign LEN_ERR = 1'b0;
`endif

    assign CMD_VALID = valid_q;
    assign CMD       = cmd_q;
    assign LATCH_LEN = len_q;
    assign DATA_R    = dr_q;
    assign DATA_G    = dg_q;
    assign DATA_B    = db_q;
    assign CMD_ERR   = err_q;
    assign ACTIVE    = (state_q != ST_IDLE);

endmodule
